heap_ctrl: RTL and testbench

//  Sequencer in front of the CMS heap-stage chain. It has two requesters: the CMS update stream
//  (key/value inserts) and the AXI-lite read side (top-of-heap reads). Only one operation touches
//  the chain at a time. Inserts are issued at a cadence the 2-cycle stage FSMs can absorb, and the

---
 rtl/heap_ctrl.sv | 147 ++++++++++++++
 tb/tb_heap_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/heap_ctrl.sv
// Sequencer in front of the CMS heap-stage chain: paces key/value inserts, drains the chain
// before a top-of-heap read bubble, and captures the two entries that emerge from the tail.
module heap_ctrl #(
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 32,
  parameter int NUM_STAGES  = 8
) (
  input  logic                   ap_clk,
  input  logic                   ap_reset,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [KEY_WIDTH-1:0]   upd_key,
  input  logic [VALUE_WIDTH-1:0] upd_value,
  input  logic                   rd_req,
  output logic                   rd_busy,
  output logic                   rd_done,
  output logic [KEY_WIDTH-1:0]   rd_key0,
  output logic [VALUE_WIDTH-1:0] rd_value0,
  output logic [KEY_WIDTH-1:0]   rd_key1,
  output logic [VALUE_WIDTH-1:0] rd_value1,
  output logic                   heap_read,
  output logic                   hs_kv_valid,
  output logic [KEY_WIDTH-1:0]   hs_key_test,
  output logic [KEY_WIDTH-1:0]   hs_key,
  output logic [VALUE_WIDTH-1:0] hs_value,
  input  logic [KEY_WIDTH-1:0]   tail_key,
  input  logic [VALUE_WIDTH-1:0] tail_value
);

  localparam int DRAIN_CYC = 2 * NUM_STAGES + 2;
  localparam int CNT_W     = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
    DRAIN,
    RD_BUB,
    RD_CAP0,
    RD_CAP1,
    RD_DONE
  } state_t;

  state_t           state;
  logic             rd_pending;
  logic             last_rd;
  logic [CNT_W-1:0] drain_cnt;

  logic in_rd_phase;
  logic rd_accept;
  logic rd_want;
  logic rd_win;

  // A request arriving in IDLE competes in the same cycle it is accepted, so the
  // arbitration looks at the fresh request as well as the registered pending flag.
  // last_rd hands the next IDLE slot to a waiting update so neither side starves.
  assign in_rd_phase = (state == DRAIN) || (state == RD_BUB) || (state == RD_CAP0) ||
                       (state == RD_CAP1) || (state == RD_DONE);
  assign rd_busy     = rd_pending | in_rd_phase;
  assign rd_accept   = rd_req & ~rd_busy;
  assign rd_want     = rd_pending | rd_accept;
  assign rd_win      = rd_want & ~(last_rd & upd_valid);
  assign upd_ready   = ~ap_reset & (state == IDLE) & ~rd_win;

  always_ff @(posedge ap_clk) begin
    if (ap_reset) begin
      state       <= IDLE;
      rd_pending  <= 1'b0;
      last_rd     <= 1'b0;
      drain_cnt   <= '0;
      rd_done     <= 1'b0;
      rd_key0     <= '0;
      rd_value0   <= '0;
      rd_key1     <= '0;
      rd_value1   <= '0;
      heap_read   <= 1'b0;
      hs_kv_valid <= 1'b0;
      hs_key_test <= '0;
      hs_key      <= '0;
      hs_value    <= '0;
    end else begin
      if (rd_accept) begin
        rd_pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (rd_win) begin
            drain_cnt <= DRAIN_LOAD;
            state     <= DRAIN;
          end else if (upd_valid) begin
            hs_key      <= upd_key;
            hs_key_test <= upd_key;
            hs_value    <= upd_value;
            hs_kv_valid <= 1'b1;
            last_rd     <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          hs_kv_valid <= 1'b0;
          state       <= GAP;
        end
        // Extra idle cycle so the 2-cycle stage FSMs are free before the next insert.
        GAP: begin
          state <= IDLE;
        end
        // The chain settles while the counter runs out; the bubble is set up on the last tick.
        DRAIN: begin
          drain_cnt <= drain_cnt - CNT_ONE;
          if (drain_cnt == CNT_ONE) begin
            heap_read <= 1'b1;
            hs_key    <= '0;
            hs_value  <= '0;
            state     <= RD_BUB;
          end
        end
        RD_BUB: begin
          heap_read  <= 1'b0;
          rd_pending <= 1'b0;
          state      <= RD_CAP0;
        end
        RD_CAP0: begin
          rd_key0   <= tail_key;
          rd_value0 <= tail_value;
          state     <= RD_CAP1;
        end
        RD_CAP1: begin
          rd_key1   <= tail_key;
          rd_value1 <= tail_value;
          rd_done   <= 1'b1;
          state     <= RD_DONE;
        end
        RD_DONE: begin
          rd_done <= 1'b0;
          last_rd <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heap_ctrl.sv
// Directed bench for heap_ctrl: insert pacing, drain/read timing, tail capture,
// read/update arbitration and reset during a drain.
module tb_heap_ctrl;

  localparam int KW = 32;
  localparam int VW = 32;
  localparam int NS = 8;
  localparam logic [KW-1:0] JUNK_K = 32'hDEAD_0000;
  localparam logic [VW-1:0] JUNK_V = 32'hBEEF_0000;

  logic          ap_clk = 1'b0;
  logic          ap_reset = 1'b1;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [KW-1:0] upd_key = '0;
  logic [VW-1:0] upd_value = '0;
  logic          rd_req = 1'b0;
  logic          rd_busy;
  logic          rd_done;
  logic [KW-1:0] rd_key0;
  logic [VW-1:0] rd_value0;
  logic [KW-1:0] rd_key1;
  logic [VW-1:0] rd_value1;
  logic          heap_read;
  logic          hs_kv_valid;
  logic [KW-1:0] hs_key_test;
  logic [KW-1:0] hs_key;
  logic [VW-1:0] hs_value;
  logic [KW-1:0] tail_key = JUNK_K;
  logic [VW-1:0] tail_value = JUNK_V;

  heap_ctrl #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .NUM_STAGES(NS)) dut (
    .ap_clk(ap_clk), .ap_reset(ap_reset),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_key(upd_key), .upd_value(upd_value),
    .rd_req(rd_req), .rd_busy(rd_busy), .rd_done(rd_done),
    .rd_key0(rd_key0), .rd_value0(rd_value0), .rd_key1(rd_key1), .rd_value1(rd_value1),
    .heap_read(heap_read), .hs_kv_valid(hs_kv_valid), .hs_key_test(hs_key_test),
    .hs_key(hs_key), .hs_value(hs_value), .tail_key(tail_key), .tail_value(tail_value)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // Tail model: the bubble shifts entry 0 out, the following passthru shift exposes entry 1.
  logic [KW-1:0] t0k = '0, t1k = '0;
  logic [VW-1:0] t0v = '0, t1v = '0;
  int tail_step = 0;
  always @(posedge ap_clk) begin
    if (heap_read === 1'b1) begin
      tail_key <= t0k; tail_value <= t0v; tail_step <= 1;
    end else if (tail_step == 1) begin
      tail_key <= t1k; tail_value <= t1v; tail_step <= 2;
    end else if (tail_step == 2) begin
      tail_key <= JUNK_K; tail_value <= JUNK_V; tail_step <= 0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Runs until rd_done (bounded); reports when heap_read and rd_done were seen.
  task automatic run_read(input int budget, output int hr_at, output int hr_cnt,
                          output logic [KW-1:0] hk_at_hr, output logic [VW-1:0] hv_at_hr,
                          output int done_at, output int kv_seen);
    hr_at = -1; hr_cnt = 0; done_at = -1; kv_seen = 0; hk_at_hr = '1; hv_at_hr = '1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (hs_kv_valid === 1'b1) kv_seen++;
      if (heap_read === 1'b1) begin
        hr_cnt++; hr_at = cyc; hk_at_hr = hs_key; hv_at_hr = hs_value;
      end
      if (rd_done === 1'b1) begin
        done_at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int c0, hr, hrn, dn, kv, n, bad;
    int pc[4];
    logic [KW-1:0] pk[4], hk;
    logic [VW-1:0] pv[4], hv;

    // 1: reset state, then a single insert
    tick(); tick();
    chk("rst_upd_ready", 64'(upd_ready), 64'd0);
    chk("rst_hs_kv_valid", 64'(hs_kv_valid), 64'd0);
    chk("rst_heap_read", 64'(heap_read), 64'd0);
    chk("rst_rd_done", 64'(rd_done), 64'd0);
    chk("rst_rd_busy", 64'(rd_busy), 64'd0);
    chk("rst_hs_key", 64'(hs_key), 64'd0);
    chk("rst_rd_key0", 64'(rd_key0), 64'd0);
    ap_reset = 1'b0;
    upd_valid = 1'b1; upd_key = 32'd5; upd_value = 32'd10;
    #1;
    chk("t1_upd_ready_idle", 64'(upd_ready), 64'd1);
    tick();
    chk("t1_kv_valid", 64'(hs_kv_valid), 64'd1);
    chk("t1_hs_key", 64'(hs_key), 64'd5);
    chk("t1_hs_key_test", 64'(hs_key_test), 64'd5);
    chk("t1_hs_value", 64'(hs_value), 64'd10);
    chk("t1_upd_ready_issue", 64'(upd_ready), 64'd0);
    upd_valid = 1'b0;
    tick();
    chk("t1_kv_valid_gap", 64'(hs_kv_valid), 64'd0);
    tick();
    chk("t1_upd_ready_back", 64'(upd_ready), 64'd1);

    // 2: four back-to-back inserts
    n = 0;
    upd_valid = 1'b1; upd_key = 32'd1; upd_value = 32'd101;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hs_kv_valid === 1'b1) begin
        pc[n] = cyc; pk[n] = hs_key; pv[n] = hs_value; n++;
        if (n < 4) begin
          upd_key = 32'(n + 1); upd_value = 32'(101 + n);
        end else begin
          upd_valid = 1'b0;
          break;
        end
      end
    end
    chk("t2_pulse_count", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        chk($sformatf("t2_key%0d", i), 64'(pk[i]), 64'(i + 1));
        chk($sformatf("t2_value%0d", i), 64'(pv[i]), 64'(101 + i));
        if (i > 0) chk($sformatf("t2_gap%0d", i), 64'(pc[i] - pc[i-1]), 64'd3);
      end
    end
    tick(); tick();

    // 3/4: read from IDLE, drain length, bubble, capture of two tail entries
    t0k = 32'd7; t0v = 32'd70; t1k = 32'd3; t1v = 32'd30;
    rd_req = 1'b1; c0 = cyc;
    #1;
    chk("t3_upd_ready_rdreq", 64'(upd_ready), 64'd0);
    tick();
    rd_req = 1'b0;
    chk("t3_rd_busy", 64'(rd_busy), 64'd1);
    run_read(60, hr, hrn, hk, hv, dn, kv);
    chk("t3_drain_len", 64'(hr - c0 - 1), 64'(2 * NS + 2));
    chk("t3_heap_read_once", 64'(hrn), 64'd1);
    chk("t3_bubble_key", 64'(hk), 64'd0);
    chk("t3_bubble_value", 64'(hv), 64'd0);
    chk("t3_done_latency", 64'(dn - hr), 64'd3);
    chk("t3_no_insert", 64'(kv), 64'd0);
    chk("t4_rd_key0", 64'(rd_key0), 64'd7);
    chk("t4_rd_value0", 64'(rd_value0), 64'd70);
    chk("t4_rd_key1", 64'(rd_key1), 64'd3);
    chk("t4_rd_value1", 64'(rd_value1), 64'd30);
    tick();
    chk("t4_rd_done_pulse", 64'(rd_done), 64'd0);
    chk("t4_rd_busy_clear", 64'(rd_busy), 64'd0);
    chk("t4_rd_key0_hold", 64'(rd_key0), 64'd7);

    // 5: arbitration; an insert first so the simultaneous case starts with last_rd clear
    upd_valid = 1'b1; upd_key = 32'd9; upd_value = 32'd90;
    tick();
    chk("t5_pre_insert_key", 64'(hs_key), 64'd9);
    upd_valid = 1'b0;
    tick(); tick();
    rd_req = 1'b1; upd_valid = 1'b1; upd_key = 32'h11; upd_value = 32'h22;
    #1;
    chk("t5_same_cycle_upd_ready", 64'(upd_ready), 64'd0);
    tick();
    rd_req = 1'b0;
    chk("t5_read_first_kv", 64'(hs_kv_valid), 64'd0);
    t0k = 32'h21; t0v = 32'h210; t1k = 32'h22; t1v = 32'h220;
    run_read(60, hr, hrn, hk, hv, dn, kv);
    chk("t5_read1_done_seen", 64'(dn > 0), 64'd1);
    chk("t5_upd_waited", 64'(kv), 64'd0);
    chk("t5_read1_key0", 64'(rd_key0), 64'h21);
    chk("t5_read1_key1", 64'(rd_key1), 64'h22);
    tick();
    rd_req = 1'b1;
    #1;
    chk("t5_update_wins", 64'(upd_ready), 64'd1);
    tick();
    chk("t5_upd_kv_valid", 64'(hs_kv_valid), 64'd1);
    chk("t5_upd_key", 64'(hs_key), 64'h11);
    chk("t5_upd_value", 64'(hs_value), 64'h22);
    chk("t5_rd2_pending", 64'(rd_busy), 64'd1);
    rd_req = 1'b0; upd_valid = 1'b0;
    t0k = 32'h31; t0v = 32'h310; t1k = 32'h32; t1v = 32'h320;
    run_read(60, hr, hrn, hk, hv, dn, kv);
    chk("t5_read2_done_seen", 64'(dn > 0), 64'd1);
    chk("t5_read2_value0", 64'(rd_value0), 64'h310);
    chk("t5_read2_value1", 64'(rd_value1), 64'h320);
    tick();

    // 6: reset while draining
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t6_busy_in_drain", 64'(rd_busy), 64'd1);
    ap_reset = 1'b1;
    tick();
    chk("t6_rst_rd_busy", 64'(rd_busy), 64'd0);
    chk("t6_rst_upd_ready", 64'(upd_ready), 64'd0);
    chk("t6_rst_heap_read", 64'(heap_read), 64'd0);
    chk("t6_rst_rd_done", 64'(rd_done), 64'd0);
    chk("t6_rst_hs_key", 64'(hs_key), 64'd0);
    chk("t6_rst_hs_value", 64'(hs_value), 64'd0);
    chk("t6_rst_rd_key0", 64'(rd_key0), 64'd0);
    chk("t6_rst_rd_value1", 64'(rd_value1), 64'd0);
    ap_reset = 1'b0;
    #1;
    chk("t6_upd_ready_after", 64'(upd_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rd_done !== 1'b0 || heap_read !== 1'b0 || rd_busy !== 1'b0) bad++;
    end
    chk("t6_read_lost", 64'(bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
